// File: rtl/pe_array_pkg.sv
// ============================================================================
//  Module   : pe_array_pkg
//  Purpose  : Shared definitions for the parameterised PE array: the beat
//             mode encoding and a constant clog2 helper for sizing counters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_array_pkg;

  // Operating mode carried with each beat through the array.
  typedef enum logic {
    MODE_PASS  = 1'b0,
    MODE_ACCUM = 1'b1
  } pe_mode_e;

  // Ceiling log2; clog2(1) = 0, clog2(31) = 5, clog2(32) = 5.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : pe_array_pkg

`default_nettype wire

// File: rtl/pe_delay_cell.sv
// ============================================================================
//  Module   : pe_delay_cell
//  Purpose  : One processing element. Combines the incoming psum with the
//             incoming ifmap according to the beat's mode, then delays the
//             {ifmap, psum, mode, valid} bundle by DELAY_CYCLES enabled cycles.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             en              - advance the delay line (0 = hold)
//             src_ifmap/psum  - operand words from the upstream neighbours
//             src_mode/valid  - beat mode and qualifier
//             dst_ifmap/psum  - delayed ifmap and combined psum
//             dst_mode/valid  - delayed mode and qualifier
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_delay_cell
  import pe_array_pkg::*;
#(
  parameter int DELAY_CYCLES = 10,
  parameter int PE_WIDTH     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PE_WIDTH-1:0] src_ifmap,
  input  logic [PE_WIDTH-1:0] src_psum,
  input  logic                src_mode,
  input  logic                src_valid,
  output logic [PE_WIDTH-1:0] dst_ifmap,
  output logic [PE_WIDTH-1:0] dst_psum,
  output logic                dst_mode,
  output logic                dst_valid
);

  logic [PE_WIDTH-1:0]     r_ifmap [DELAY_CYCLES];
  logic [PE_WIDTH-1:0]     r_psum  [DELAY_CYCLES];
  logic [DELAY_CYCLES-1:0] r_mode;
  logic [DELAY_CYCLES-1:0] r_valid;
  logic [PE_WIDTH-1:0]     w_psum_next;

  // Sum wraps modulo 2^PE_WIDTH by truncation to the word width.
  always_comb begin
    w_psum_next = src_psum;
    if (pe_mode_e'(src_mode) == MODE_ACCUM) begin
      w_psum_next = src_psum + src_ifmap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY_CYCLES; i++) begin
        r_ifmap[i] <= '0;
        r_psum[i]  <= '0;
        r_mode[i]  <= 1'b0;
        r_valid[i] <= 1'b0;
      end
    end else if (en) begin
      r_ifmap[0] <= src_ifmap;
      r_psum[0]  <= w_psum_next;
      r_mode[0]  <= src_mode;
      r_valid[0] <= src_valid;
      for (int i = 1; i < DELAY_CYCLES; i++) begin
        r_ifmap[i] <= r_ifmap[i-1];
        r_psum[i]  <= r_psum[i-1];
        r_mode[i]  <= r_mode[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign dst_ifmap = r_ifmap[DELAY_CYCLES-1];
  assign dst_psum  = r_psum[DELAY_CYCLES-1];
  assign dst_mode  = r_mode[DELAY_CYCLES-1];
  assign dst_valid = r_valid[DELAY_CYCLES-1];

endmodule : pe_delay_cell

`default_nettype wire

// File: rtl/param_pe_array.sv
// ============================================================================
//  Module   : param_pe_array
//  Purpose  : ROWS x COLS array of pe_delay_cell. Psums flow straight down the
//             columns, ifmaps flow diagonally (down-right). Every beat emerges
//             from the bottom row ROWS*DELAY_CYCLES enabled cycles after it
//             was accepted. An in-flight counter drives busy.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             en              - global advance (0 stalls everything)
//             mode            - 0 = PASS, 1 = ACCUM, sampled with the beat
//             in_valid        - qualifies ifmap_edge_in / psum_in
//             ifmap_edge_in   - edge ifmaps, slot e = c - r + ROWS - 1
//             psum_in         - psum into row 0, slot c
//             psum_out        - psum leaving row ROWS-1, slot c
//             out_valid       - qualifies psum_out
//             busy            - any beat in flight
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_pe_array
  import pe_array_pkg::*;
#(
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int DELAY_CYCLES = 10,
  parameter int PE_WIDTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              mode,
  input  logic                              in_valid,
  input  logic [(ROWS+COLS-1)*PE_WIDTH-1:0] ifmap_edge_in,
  input  logic [COLS*PE_WIDTH-1:0]          psum_in,
  output logic [COLS*PE_WIDTH-1:0]          psum_out,
  output logic                              out_valid,
  output logic                              busy
);

  localparam int LATENCY = ROWS * DELAY_CYCLES;
  localparam int CNT_W   = clog2(LATENCY + 1);

  // Row index r of the psum/mode/valid arrays is the input to cell row r;
  // index ROWS is the bottom-row output.
  logic [PE_WIDTH-1:0] w_psum      [ROWS+1][COLS];
  logic                w_mode      [ROWS+1][COLS];
  logic                w_valid     [ROWS+1][COLS];
  logic [PE_WIDTH-1:0] w_ifmap_src [ROWS][COLS];
  logic [PE_WIDTH-1:0] w_ifmap_dst [ROWS][COLS];

  logic             w_out_valid;
  logic             w_accept;
  logic             w_retire;
  logic             w_unused;
  logic [CNT_W-1:0] r_count;

  // Row-0 column inputs share the global mode and valid.
  generate
    for (genvar c = 0; c < COLS; c++) begin : g_in
      assign w_psum[0][c]  = psum_in[c*PE_WIDTH +: PE_WIDTH];
      assign w_mode[0][c]  = mode;
      assign w_valid[0][c] = in_valid;
    end
  endgenerate

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
        if (r > 0 && c > 0) begin : g_diag
          assign w_ifmap_src[r][c] = w_ifmap_dst[r-1][c-1];
        end else begin : g_edge
          assign w_ifmap_src[r][c] = ifmap_edge_in[(c-r+ROWS-1)*PE_WIDTH +: PE_WIDTH];
        end

        pe_delay_cell #(
          .DELAY_CYCLES (DELAY_CYCLES),
          .PE_WIDTH     (PE_WIDTH)
        ) u_cell (
          .clk       (clk),
          .rst       (rst),
          .en        (en),
          .src_ifmap (w_ifmap_src[r][c]),
          .src_psum  (w_psum[r][c]),
          .src_mode  (w_mode[r][c]),
          .src_valid (w_valid[r][c]),
          .dst_ifmap (w_ifmap_dst[r][c]),
          .dst_psum  (w_psum[r+1][c]),
          .dst_mode  (w_mode[r+1][c]),
          .dst_valid (w_valid[r+1][c])
        );
      end
    end
  endgenerate

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_out
      assign psum_out[c*PE_WIDTH +: PE_WIDTH] = w_psum[ROWS][c];
    end
  endgenerate

  // All columns carry the same valid bit; OR them so none is left dangling.
  always_comb begin
    w_out_valid = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      w_out_valid = w_out_valid | w_valid[ROWS][c];
    end
  end

  // Bottom-row mode and edge-leaving ifmaps have no consumer.
  always_comb begin
    w_unused = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      w_unused = w_unused ^ w_mode[ROWS][c];
      for (int r = 0; r < ROWS; r++) begin
        w_unused = w_unused ^ (^w_ifmap_dst[r][c]);
      end
    end
  end

  assign out_valid = w_out_valid;

  // A beat retires only on an enabled cycle; out_valid merely holds while en=0.
  assign w_accept = en & in_valid;
  assign w_retire = en & w_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy = (r_count != '0);

endmodule : param_pe_array

`default_nettype wire

// File: tb/tb_param_pe_array.sv
// ============================================================================
//  Module   : tb_param_pe_array
//  Purpose  : Self-checking bench for param_pe_array (3x3, D=10, W=4).
//             Expected psums are pushed at acceptance with their due enabled
//             cycle and popped when the array presents out_valid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_pe_array;

  localparam int ROWS  = 3;
  localparam int COLS  = 3;
  localparam int D     = 10;
  localparam int W     = 4;
  localparam int LAT   = ROWS * D;
  localparam int PSW   = COLS * W;
  localparam int EW    = (ROWS + COLS - 1) * W;

  logic           clk;
  logic           rst;
  logic           en;
  logic           mode;
  logic           in_valid;
  logic [EW-1:0]  ifmap_edge_in;
  logic [PSW-1:0] psum_in;
  logic [PSW-1:0] psum_out;
  logic           out_valid;
  logic           busy;

  param_pe_array #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .DELAY_CYCLES (D),
    .PE_WIDTH     (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .mode          (mode),
    .in_valid      (in_valid),
    .ifmap_edge_in (ifmap_edge_in),
    .psum_in       (psum_in),
    .psum_out      (psum_out),
    .out_valid     (out_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PSW-1:0] data;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   ecyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closed form: the ifmap reaching PE(r,c) always originates at edge slot
  // c-r+ROWS-1, provided the edge inputs are held while the beat is in flight.
  function automatic logic [PSW-1:0] model(input logic m, input logic [PSW-1:0] p,
                                           input logic [EW-1:0] e);
    logic [PSW-1:0] res;
    logic [W-1:0]   acc;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = p[c*W +: W];
      if (m) begin
        for (int r = 0; r < ROWS; r++) begin
          acc = acc + e[(c-r+ROWS-1)*W +: W];
        end
      end
      res[c*W +: W] = acc;
    end
    return res;
  endfunction

  // One clock cycle: check outputs of the current cycle, update scoreboard,
  // then advance past the next rising edge.
  task automatic cycle();
    exp_t e;
    check("busy", busy, (sb.size() != 0));
    check("count", 32'(dut.r_count), sb.size());
    if (en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("psum_out", psum_out, e.data);
          check("latency", ecyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due == ecyc) begin
        check("missed_out", out_valid, 1);
        e = sb.pop_front();
      end
    end
    if (rst) begin
      sb.delete();
    end else if (en && in_valid) begin
      e.data = model(mode, psum_in, ifmap_edge_in);
      e.due  = ecyc + LAT;
      sb.push_back(e);
    end
    if (en) ecyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (2) cycle();
  endtask

  logic [EW-1:0] ramp;

  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
    ifmap_edge_in = '0; psum_in = '0;
    vectors = 0; miscompares = 0; ecyc = 0;
    for (int e = 0; e < ROWS + COLS - 1; e++) ramp[e*W +: W] = W'(e + 1);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_psum_out", psum_out, 0);
    rst = 1'b0;
    en  = 1'b1;

    // PASS single beat
    mode = 1'b0; psum_in = {4'd3, 4'd2, 4'd1}; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain();

    // ACCUM with ramp edge
    ifmap_edge_in = ramp; mode = 1'b1; psum_in = '0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain();

    // ACCUM wrap
    ifmap_edge_in = {5{4'h1}}; mode = 1'b1; psum_in = 12'hFFF; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain();

    // Stall: en=0 for 5 cycles starting at cycle 12, in_valid ignored
    ifmap_edge_in = ramp; mode = 1'b1; psum_in = 12'h5A3; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (11) cycle();
    en = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      psum_in = PSW'($urandom());
      mode    = 1'($urandom());
      cycle();
    end
    en = 1'b1; in_valid = 1'b0;
    drain();

    // 30 back-to-back beats, alternating mode
    for (int i = 0; i < LAT; i++) begin
      mode = i[0]; psum_in = PSW'($urandom()); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("peak_count", 32'(dut.r_count), LAT);
    drain();

    // Reset mid-flight: 5 beats, rst at cycle 15
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      psum_in = PSW'($urandom()); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("post_rst_busy", busy, 0);
    repeat (40) cycle();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_param_pe_array

`default_nettype wire
